// File: rtl/shift_register_sequencer.sv
// Command sequencer for a 4-bit universal shift register: turns one LOAD/SHIFT/ROTATE/ZERO
// command into the right number of mode-select cycles on the register, then pulses o_done.
module shift_register_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic             i_dir,
    input  logic             i_fill,
    input  logic [CNT_W-1:0] i_count,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic [WIDTH-1:0] i_a_par,
    output logic             o_s1,
    output logic             o_s0,
    output logic [WIDTH-1:0] o_i_par,
    output logic             o_msb_in,
    output logic             o_lsb_in,
    output logic             o_ready,
    output logic             o_done
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SHIFT = 2'b01;
    localparam logic [1:0] OP_ROT   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_s1;
    logic             r_s0;
    logic [WIDTH-1:0] r_i_par;
    logic             r_msb_fill;
    logic             r_lsb_fill;
    logic             r_rot_r;
    logic             r_rot_l;
    logic             r_ready;
    logic             r_done;

    logic             w_s1;
    logic             w_s0;
    logic [WIDTH-1:0] w_i_par;
    logic             w_msb_fill;
    logic             w_lsb_fill;
    logic             w_rot_r;
    logic             w_rot_l;
    logic [CNT_W-1:0] w_cnt;

    // Decode of the incoming command into the outputs it will hold for the whole EXEC phase.
    always_comb begin
        w_s1       = 1'b0;
        w_s0       = 1'b0;
        w_i_par    = '0;
        w_msb_fill = 1'b0;
        w_lsb_fill = 1'b0;
        w_rot_r    = 1'b0;
        w_rot_l    = 1'b0;
        w_cnt      = CNT_W'(1);
        case (i_op)
            OP_LOAD: begin
                {w_s1, w_s0} = 2'b11;
                w_i_par      = i_data_in;
            end
            OP_SHIFT: begin
                {w_s1, w_s0} = i_dir ? 2'b10 : 2'b01;
                w_msb_fill   = ~i_dir & i_fill;
                w_lsb_fill   = i_dir & i_fill;
                w_cnt        = i_count;
            end
            OP_ROT: begin
                {w_s1, w_s0} = i_dir ? 2'b10 : 2'b01;
                w_rot_r      = ~i_dir;
                w_rot_l      = i_dir;
                w_cnt        = i_count;
            end
            default: begin
                {w_s1, w_s0} = 2'b11;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_s1       <= 1'b0;
            r_s0       <= 1'b0;
            r_i_par    <= '0;
            r_msb_fill <= 1'b0;
            r_lsb_fill <= 1'b0;
            r_rot_r    <= 1'b0;
            r_rot_l    <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_ready <= 1'b0;
                        r_cnt   <= w_cnt;
                        if (w_cnt == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_EXEC;
                            r_s1       <= w_s1;
                            r_s0       <= w_s0;
                            r_i_par    <= w_i_par;
                            r_msb_fill <= w_msb_fill;
                            r_lsb_fill <= w_lsb_fill;
                            r_rot_r    <= w_rot_r;
                            r_rot_l    <= w_rot_l;
                        end
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_s1       <= 1'b0;
                        r_s0       <= 1'b0;
                        r_i_par    <= '0;
                        r_msb_fill <= 1'b0;
                        r_lsb_fill <= 1'b0;
                        r_rot_r    <= 1'b0;
                        r_rot_l    <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Rotate feeds the register's own end bit straight back, so that path stays combinational.
    assign o_msb_in = r_msb_fill | (r_rot_r & i_a_par[0]);
    assign o_lsb_in = r_lsb_fill | (r_rot_l & i_a_par[WIDTH-1]);
    assign o_s1     = r_s1;
    assign o_s0     = r_s0;
    assign o_i_par  = r_i_par;
    assign o_ready  = r_ready;
    assign o_done   = r_done;

    logic w_unused;
    assign w_unused = &{1'b0, i_a_par};

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Bench: sequencer driving a behavioural 4-bit universal shift register; table of commands
// plus hand-written abort and busy-start sequences.
module tb_shift_register_sequencer;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SHIFT = 2'b01;
    localparam logic [1:0] OP_ROT   = 2'b10;
    localparam logic [1:0] OP_ZERO  = 2'b11;

    logic       clk = 1'b0;
    logic       clear;
    logic       start;
    logic [1:0] op;
    logic       dir;
    logic       fill;
    logic [2:0] count;
    logic [3:0] data_in;
    logic [3:0] a_par;
    logic       s1, s0, msb_in, lsb_in, ready, done;
    logic [3:0] i_par;
    logic       reg_clr_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_register_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .i_clk(clk), .i_clear(clear), .i_start(start), .i_op(op), .i_dir(dir),
        .i_fill(fill), .i_count(count), .i_data_in(data_in), .i_a_par(a_par),
        .o_s1(s1), .o_s0(s0), .o_i_par(i_par), .o_msb_in(msb_in), .o_lsb_in(lsb_in),
        .o_ready(ready), .o_done(done)
    );

    // Universal shift register with its own clear, independent of the sequencer's.
    always @(posedge clk) begin
        if (!reg_clr_b) a_par <= 4'b0000;
        else case ({s1, s0})
            2'b01:   a_par <= {msb_in, a_par[3:1]};
            2'b10:   a_par <= {a_par[2:0], lsb_in};
            2'b11:   a_par <= i_par;
            default: a_par <= a_par;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic       dir;
        logic       fill;
        logic [2:0] cnt;
        logic [3:0] data;
        logic [3:0] exp_a;
        int         exp_n;
        logic [1:0] exp_mode;
    } vec_t;

    task automatic run_cmd(input string name, input logic [1:0] c_op, input logic c_dir,
                           input logic c_fill, input logic [2:0] c_cnt, input logic [3:0] c_data,
                           input logic [3:0] exp_a, input int exp_n, input logic [1:0] exp_mode,
                           input bit glitch);
        int n_act;
        int done_at;
        bit mode_ok;
        bit ready_ok;
        @(negedge clk);
        op = c_op; dir = c_dir; fill = c_fill; count = c_cnt; data_in = c_data; start = 1'b1;
        @(posedge clk);
        #1;
        // Command inputs are scrambled after acceptance; a glitch run also re-requests a LOAD.
        start = glitch;
        op = glitch ? OP_LOAD : ~c_op;
        data_in = glitch ? 4'b1111 : ~c_data;
        dir = ~c_dir; fill = ~c_fill; count = ~c_cnt;
        n_act = 0; done_at = 0; mode_ok = 1'b1; ready_ok = 1'b1;
        for (int i = 1; i <= 12 && done_at == 0; i++) begin
            @(negedge clk);
            if (i == 2) start = 1'b0;
            if ({s1, s0} != 2'b00) begin
                n_act++;
                if ({s1, s0} != exp_mode) mode_ok = 1'b0;
            end
            if (ready) ready_ok = 1'b0;
            if (done) begin
                done_at = i;
                chk({name, " a_par"}, int'(a_par), int'(exp_a));
            end
        end
        start = 1'b0;
        chk({name, " active_cycles"}, n_act, exp_n);
        chk({name, " done_cycle"}, done_at, exp_n + 1);
        chk({name, " mode_value"}, int'(mode_ok), 1);
        chk({name, " ready_low_busy"}, int'(ready_ok), 1);
        @(negedge clk);
        chk({name, " done_then_ready"}, int'({done, ready}), 1);
    endtask

    vec_t vecs[11];

    initial begin
        int hold_ok;
        vecs[0]  = '{OP_LOAD,  1'b0, 1'b0, 3'd5, 4'b1010, 4'b1010, 1, 2'b11};
        vecs[1]  = '{OP_SHIFT, 1'b0, 1'b1, 3'd2, 4'b0000, 4'b1110, 2, 2'b01};
        vecs[2]  = '{OP_ROT,   1'b1, 1'b0, 3'd3, 4'b0000, 4'b0111, 3, 2'b10};
        vecs[3]  = '{OP_ROT,   1'b0, 1'b0, 3'd4, 4'b0000, 4'b0111, 4, 2'b01};
        vecs[4]  = '{OP_SHIFT, 1'b0, 1'b1, 3'd0, 4'b0000, 4'b0111, 0, 2'b00};
        vecs[5]  = '{OP_ZERO,  1'b0, 1'b1, 3'd6, 4'b1111, 4'b0000, 1, 2'b11};
        vecs[6]  = '{OP_LOAD,  1'b0, 1'b0, 3'd0, 4'b1001, 4'b1001, 1, 2'b11};
        vecs[7]  = '{OP_SHIFT, 1'b1, 1'b1, 3'd2, 4'b0000, 4'b0111, 2, 2'b10};
        vecs[8]  = '{OP_ROT,   1'b1, 1'b0, 3'd7, 4'b0000, 4'b1011, 7, 2'b10};
        vecs[9]  = '{OP_SHIFT, 1'b0, 1'b0, 3'd1, 4'b0000, 4'b0101, 1, 2'b01};
        vecs[10] = '{OP_LOAD,  1'b0, 1'b0, 3'd3, 4'b1000, 4'b1000, 1, 2'b11};

        // Reset with a start request held high the whole time.
        clear = 1'b1; reg_clr_b = 1'b0; start = 1'b1; op = OP_LOAD; dir = 1'b0;
        fill = 1'b1; count = 3'd3; data_in = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b0; reg_clr_b = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("reset ready", int'(ready), 1);
        chk("reset done", int'(done), 0);
        chk("reset mode", int'({s1, s0}), 0);
        chk("reset i_par", int'(i_par), 0);
        chk("reset serial", int'({msb_in, lsb_in}), 0);
        chk("reset a_par", int'(a_par), 0);

        for (int v = 0; v < 11; v++)
            run_cmd($sformatf("vec%0d", v), vecs[v].op, vecs[v].dir, vecs[v].fill, vecs[v].cnt,
                    vecs[v].data, vecs[v].exp_a, vecs[v].exp_n, vecs[v].exp_mode, 1'b0);

        // Abort: ROTATE right x7 on 1000, Clear sampled on the second step's edge.
        @(negedge clk);
        op = OP_ROT; dir = 1'b0; fill = 1'b0; count = 3'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        chk("abort a_par", int'(a_par), 4'b0010);
        chk("abort ready", int'(ready), 1);
        chk("abort mode", int'({s1, s0}), 0);
        hold_ok = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || {s1, s0} != 2'b00 || a_par != 4'b0010 || !ready) hold_ok = 0;
        end
        chk("abort hold_no_done", hold_ok, 1);

        // Start held during EXEC must be ignored: SHIFT left fill 1 x3 from 0010.
        run_cmd("busy_start", OP_SHIFT, 1'b1, 1'b1, 3'd3, 4'b0000, 4'b0111, 3, 2'b10, 1'b1);
        repeat (3) @(negedge clk);
        chk("idle after busy a_par", int'(a_par), 4'b0111);
        chk("idle after busy ready", int'(ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
